// File: rtl/bbox_detect_pkg.sv
// -----------------------------------------------------------------------------
// bbox_detect_pkg
//   Shared video definitions for the segmentation / overlay chain:
//   coordinate and count widths, default frame geometry and the state
//   encoding of the bounding-box measurement FSM.
// -----------------------------------------------------------------------------
package bbox_detect_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned COUNT_W   = 21;
    localparam int unsigned DEF_IMG_W = 1280;
    localparam int unsigned DEF_IMG_H = 720;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LATCH  = 2'd2,
        ST_WAIT   = 2'd3
    } bbox_state_t;

endpackage

// File: rtl/bbox_detect_pixel_pos_counter.sv
// -----------------------------------------------------------------------------
// pixel_pos_counter
//   Tracks the (x, y) position of the pixel currently on the bus. The outputs
//   are the coordinate of the pixel sampled this cycle; the count advances on
//   the clock edge that consumes it.
//
//   Ports:
//     clk, rst_n   pixel clock, asynchronous active-low reset
//     de           data enable, advances the position
//     vsync        vertical sync, clears the position while high
//     x_pos, y_pos current pixel coordinate
// -----------------------------------------------------------------------------
module pixel_pos_counter
    import bbox_detect_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de,
    input  logic               vsync,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vsync) begin
            x_d = '0;
            y_d = '0;
        end else if (de) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;

endmodule

// File: rtl/bbox_detect.sv
// -----------------------------------------------------------------------------
// bbox_detect
//   Measures the bounding box of foreground (non-zero) pixels in a binary mask
//   stream and reports it once per frame, at frame end. Video is forwarded
//   with a fixed one-cycle delay.
//
//   Ports:
//     clk, rst_n                    pixel clock, asynchronous active-low reset
//     de_in, hsync_in, vsync_in     video timing in (vsync active-high)
//     pixel_in                      mask pixel, foreground iff non-zero
//     de_out, hsync_out, vsync_out  timing delayed one cycle
//     pixel_out                     pixel delayed one cycle
//     left_top_x/y                  min foreground coordinate, last valid frame
//     right_bottom_x/y              max foreground coordinate, last valid frame
//     pixel_count                   foreground count of last completed frame
//     bbox_valid                    last completed frame met MIN_AREA
//     frame_done                    one-cycle pulse when results update
// -----------------------------------------------------------------------------
module bbox_detect
    import bbox_detect_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned MIN_AREA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [23:0]        pixel_in,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [23:0]        pixel_out,
    output logic [COORD_W-1:0] left_top_x,
    output logic [COORD_W-1:0] left_top_y,
    output logic [COORD_W-1:0] right_bottom_x,
    output logic [COORD_W-1:0] right_bottom_y,
    output logic [COUNT_W-1:0] pixel_count,
    output logic               bbox_valid,
    output logic               frame_done
);

    localparam logic [COUNT_W-1:0] MIN_COUNT = COUNT_W'(MIN_AREA);

    logic [COORD_W-1:0] x_pos, y_pos;

    pixel_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de_in),
        .vsync (vsync_in),
        .x_pos (x_pos),
        .y_pos (y_pos)
    );

    // vsync_q doubles as the edge-detect history and the vsync passthrough.
    logic               vsync_q;
    logic               de_q, hsync_q;
    logic [23:0]        pixel_q;

    bbox_state_t        state_q, state_d;

    logic [COORD_W-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
    logic [COORD_W-1:0] max_x_q, max_x_d, max_y_q, max_y_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               found_q, found_d;

    logic [COORD_W-1:0] left_top_x_q, left_top_x_d, left_top_y_q, left_top_y_d;
    logic [COORD_W-1:0] right_bottom_x_q, right_bottom_x_d;
    logic [COORD_W-1:0] right_bottom_y_q, right_bottom_y_d;
    logic [COUNT_W-1:0] pixel_count_q, pixel_count_d;
    logic               bbox_valid_q, bbox_valid_d;
    logic               frame_done_q, frame_done_d;

    logic vsync_rise, vsync_fall;
    logic frame_start, latch, pix_hit;

    // Frame control
    always_comb begin
        vsync_rise  = vsync_in & ~vsync_q;
        vsync_fall  = ~vsync_in & vsync_q;
        state_d     = state_q;
        frame_start = 1'b0;
        latch       = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (vsync_fall) begin
                    frame_start = 1'b1;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                latch   = 1'b1;
                state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulators. The clear at frame start is folded into the same update
    // so a foreground pixel in the first active cycle is not lost.
    always_comb begin
        min_x_d = frame_start ? '1 : min_x_q;
        min_y_d = frame_start ? '1 : min_y_q;
        max_x_d = frame_start ? '0 : max_x_q;
        max_y_d = frame_start ? '0 : max_y_q;
        count_d = frame_start ? '0 : count_q;
        found_d = frame_start ? 1'b0 : found_q;

        pix_hit = ((state_q == ST_ACTIVE) || frame_start) && de_in && !vsync_in
                  && (pixel_in != '0);
        if (pix_hit) begin
            if (x_pos < min_x_d) min_x_d = x_pos;
            if (y_pos < min_y_d) min_y_d = y_pos;
            if (x_pos > max_x_d) max_x_d = x_pos;
            if (y_pos > max_y_d) max_y_d = y_pos;
            if (count_d != '1) count_d = count_d + 1'b1;
            found_d = 1'b1;
        end
    end

    // Reported results
    always_comb begin
        left_top_x_d     = left_top_x_q;
        left_top_y_d     = left_top_y_q;
        right_bottom_x_d = right_bottom_x_q;
        right_bottom_y_d = right_bottom_y_q;
        pixel_count_d    = pixel_count_q;
        bbox_valid_d     = bbox_valid_q;
        frame_done_d     = 1'b0;
        if (latch) begin
            pixel_count_d = count_q;
            bbox_valid_d  = (count_q >= MIN_COUNT);
            frame_done_d  = 1'b1;
            // found_q keeps the reset-value min/max out of the outputs if
            // MIN_AREA is ever set to 0 and a frame has no foreground.
            if (bbox_valid_d && found_q) begin
                left_top_x_d     = min_x_q;
                left_top_y_d     = min_y_q;
                right_bottom_x_d = max_x_q;
                right_bottom_y_d = max_y_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            vsync_q          <= 1'b0;
            de_q             <= 1'b0;
            hsync_q          <= 1'b0;
            pixel_q          <= '0;
            min_x_q          <= '1;
            min_y_q          <= '1;
            max_x_q          <= '0;
            max_y_q          <= '0;
            count_q          <= '0;
            found_q          <= 1'b0;
            left_top_x_q     <= '0;
            left_top_y_q     <= '0;
            right_bottom_x_q <= '0;
            right_bottom_y_q <= '0;
            pixel_count_q    <= '0;
            bbox_valid_q     <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            vsync_q          <= vsync_in;
            de_q             <= de_in;
            hsync_q          <= hsync_in;
            pixel_q          <= pixel_in;
            min_x_q          <= min_x_d;
            min_y_q          <= min_y_d;
            max_x_q          <= max_x_d;
            max_y_q          <= max_y_d;
            count_q          <= count_d;
            found_q          <= found_d;
            left_top_x_q     <= left_top_x_d;
            left_top_y_q     <= left_top_y_d;
            right_bottom_x_q <= right_bottom_x_d;
            right_bottom_y_q <= right_bottom_y_d;
            pixel_count_q    <= pixel_count_d;
            bbox_valid_q     <= bbox_valid_d;
            frame_done_q     <= frame_done_d;
        end
    end

    assign de_out         = de_q;
    assign hsync_out      = hsync_q;
    assign vsync_out      = vsync_q;
    assign pixel_out      = pixel_q;
    assign left_top_x     = left_top_x_q;
    assign left_top_y     = left_top_y_q;
    assign right_bottom_x = right_bottom_x_q;
    assign right_bottom_y = right_bottom_y_q;
    assign pixel_count    = pixel_count_q;
    assign bbox_valid     = bbox_valid_q;
    assign frame_done     = frame_done_q;

endmodule

// File: doc/bbox_detect.md
# bbox_detect

Measures the axis-aligned bounding box of foreground pixels in a binary-mask video stream and reports it once per frame. It sits at the end of the segmentation chain and drives the coordinate inputs of the box-overlay stage. Video is passed through with a fixed one-cycle delay. Coordinates are latched at frame end, so downstream overlay always draws the previous complete frame's box.

## Interface
- IMG_W, 1280: active pixels per line.
- IMG_H, 720: active lines per frame.
- MIN_AREA, 1: minimum foreground pixel count for a frame's box to be reported valid.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- de_in  in  1  data enable.
- hsync_in  in  1  horizontal sync, passed through only.
- vsync_in  in  1  vertical sync, active-high.
- pixel_in  in  24  mask pixel; foreground iff pixel_in != 0.
- de_out, hsync_out, vsync_out  out  1 each  inputs delayed one cycle.
- pixel_out  out  24  pixel_in delayed one cycle.
- left_top_x, left_top_y  out  11 each  minimum foreground x and y of last reported frame.
- right_bottom_x, right_bottom_y  out  11 each  maximum foreground x and y of last reported frame.
- pixel_count  out  21  foreground pixel count of last completed frame.
- bbox_valid  out  1  last completed frame had pixel_count >= MIN_AREA.
- frame_done  out  1  one-cycle pulse when outputs update.

## Operation
- Position counter x_pos/y_pos (11 bit):
  - vsync_in high: clear both to 0.
  - de_in high: x increments; at IMG_W-1, x goes to 0 and y increments; at IMG_H-1, y goes to 0 on the same wrap.
- A pixel's coordinate is the counter value in the cycle it is sampled, before increment.
- Accumulators: min_x, min_y, max_x, max_y, count, and found.
  - Cleared at frame start: min to 11'h7FF, max to 0, count to 0, found to 0.
  - On each foreground pixel with de_in=1 and vsync_in=0, update min/max and increment count; count saturates at 2^21-1.
- FSM:
  - IDLE: after reset. Wait for a vsync_in falling edge, then clear accumulators and go to ACTIVE.
  - ACTIVE: accumulate. On a vsync_in rising edge, go to LATCH.
  - LATCH: one cycle. pixel_count <= count; bbox_valid <= (count >= MIN_AREA); if valid, copy min/max to the coordinate outputs, else the coordinate outputs hold their previous values; frame_done=1. Then go to WAIT.
  - WAIT: on a vsync_in falling edge, clear accumulators and go to ACTIVE.
- Edge detection uses a registered copy of vsync_in.
- A vsync_in rise mid-frame, i.e. a short frame, is treated as frame end and reported normally.
- de_in high while vsync_in high is ignored.
- Reset mid-frame: all state and outputs clear and the FSM returns to IDLE. The partial frame in progress is never reported.

## Timing
- Reset values: every output is 0, including the video outputs, coordinates, pixel_count, bbox_valid and frame_done.
- Video path: exactly one cycle latency for all four signals; no gaps, no back-pressure.
- Box outputs and frame_done change on the clock edge ending LATCH, which is 2 cycles after the first cycle in which vsync_in=1 is sampled.
- Outputs are stable until the next LATCH.
- Accumulator updates take one cycle. A foreground pixel sampled in the cycle immediately before vsync_in rises is included in that frame.

## Structure
- Shared video package holds:
  - coordinate width (11)
  - count width (21)
  - default IMG_W/IMG_H
  - FSM state encoding (IDLE, ACTIVE, LATCH, WAIT)
- Sub-module pixel_pos_counter contains the x/y counter with the vsync clear and wrap rules. The overlay stage also needs it, so it is reusable there.
- The top level holds the FSM, the accumulators and the passthrough registers.

## Test plan
- **Single pixel:** one foreground pixel at (100,50) in a 1280x720 frame, MIN_AREA=1. Required: lt=(100,50), rb=(100,50), pixel_count=1, bbox_valid=1, one frame_done pulse.
- **Filled rectangle:** foreground over x 10..19, y 20..29. Required: lt=(10,20), rb=(19,29), pixel_count=100.
- **Corners:** foreground at (0,0) and (1279,719). Required: lt=(0,0), rb=(1279,719), which checks wrap and boundary handling.
- **Empty frame:** run the rectangle frame, then an all-zero frame. Required: bbox_valid=0, pixel_count=0, coordinates still (10,20)/(19,29). Repeat with MIN_AREA=150 on the rectangle frame: required bbox_valid=0.
- **Reset mid-frame:** assert rst_n=0 at line 300. Required: all outputs 0 immediately; the frame in progress is not reported; the next full frame reports correctly.
- **Passthrough:** random pixel_in/de_in/hsync_in/vsync_in. Required: outputs equal the inputs delayed exactly one cycle in every cycle.
